// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light sensor path: direction indices and default timing.
package traffic_pkg;

  localparam int NUM_DIRS = 4;

  // Direction indices; the controller uses the same ordering.
  localparam int DIR_N = 0;
  localparam int DIR_E = 1;
  localparam int DIR_S = 2;
  localparam int DIR_W = 3;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_STUCK_CYCLES    = 64;

  typedef logic [NUM_DIRS-1:0] dir_vec_t;

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// Detector, green-feedback and request signals between the sensor field, the conditioner and the controller.
interface traffic_sensor_conditioner_if;
  import traffic_pkg::*;

  // All signals are plain levels with no handshake: detectors are raw and asynchronous,
  // greens and requests are sampled on every rising clk edge.
  logic     det_n, det_e, det_s, det_w;
  logic     Gn, Ge, Gs, Gw;
  logic     N, E, S, W;
  dir_vec_t stuck;

  modport master (
    output det_n, det_e, det_s, det_w,
    output Gn, Ge, Gs, Gw,
    input  N, E, S, W,
    input  stuck
  );

  modport slave (
    input  det_n, det_e, det_s, det_w,
    input  Gn, Ge, Gs, Gw,
    output N, E, S, W,
    output stuck
  );

endinterface

// File: rtl/traffic_sensor_channel.sv
// One direction: 2-flop synchroniser, counting debouncer, request latch cleared by green, stuck detector.
module traffic_sensor_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic g,
  output logic req,
  output logic stuck
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);

  logic          sync1;
  logic          sync_q;
  logic          deb;
  logic [CW-1:0] cnt;
  logic [SW-1:0] scnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync1  <= raw;
      sync_q <= sync1;
    end
  end

  // The new level is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (sync_q != deb) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync_q;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Green clears first so a vehicle still present re-requests only after green drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req <= 1'b0;
    end else if (g) begin
      req <= 1'b0;
    end else if (deb) begin
      req <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scnt <= '0;
    end else if (!deb) begin
      scnt <= '0;
    end else if (scnt != SW'(STUCK_CYCLES)) begin
      scnt <= scnt + 1'b1;
    end
  end

  // Informational only: a stuck detector still gets its direction served.
  assign stuck = (scnt == SW'(STUCK_CYCLES));

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Four independent detector channels mapped onto the controller's N/E/S/W request inputs.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset_n,
  traffic_sensor_conditioner_if.slave  bus
);

  dir_vec_t raw;
  dir_vec_t g;
  dir_vec_t req;
  dir_vec_t stuck_v;

  assign raw[DIR_N] = bus.det_n;
  assign raw[DIR_E] = bus.det_e;
  assign raw[DIR_S] = bus.det_s;
  assign raw[DIR_W] = bus.det_w;

  assign g[DIR_N] = bus.Gn;
  assign g[DIR_E] = bus.Ge;
  assign g[DIR_S] = bus.Gs;
  assign g[DIR_W] = bus.Gw;

  for (genvar d = DIR_N; d <= DIR_W; d++) begin : g_chan
    traffic_sensor_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw[d]),
      .g       (g[d]),
      .req     (req[d]),
      .stuck   (stuck_v[d])
    );
  end

  assign bus.N     = req[DIR_N];
  assign bus.E     = req[DIR_E];
  assign bus.S     = req[DIR_S];
  assign bus.W     = req[DIR_W];
  assign bus.stuck = stuck_v;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: windowed-history reference model plus directed edge-exact checks.
module tb_traffic_sensor_conditioner;
  import traffic_pkg::*;

  localparam int DEB = DEF_DEBOUNCE_CYCLES;
  localparam int STK = DEF_STUCK_CYCLES;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] det = '0;
  logic [3:0] g = '0;
  logic [3:0] req;
  logic [3:0] stuck;

  int checks = 0;
  int errors = 0;

  traffic_sensor_conditioner_if bus ();

  assign bus.det_n = det[0];
  assign bus.det_e = det[1];
  assign bus.det_s = det[2];
  assign bus.det_w = det[3];
  assign bus.Gn    = g[0];
  assign bus.Ge    = g[1];
  assign bus.Gs    = g[2];
  assign bus.Gw    = g[3];
  assign req       = {bus.W, bus.S, bus.E, bus.N};
  assign stuck     = bus.stuck;

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .STUCK_CYCLES    (STK)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // reference model: a direction's level flips once the last DEB synced samples (raw seen two
  // edges earlier) all disagree with it; requests and stuck follow from that level
  bit         m_hist [4][$];
  bit         m_deb  [4];
  bit         m_req  [4];
  int         m_run  [4];
  logic [7:0] exp_q  [$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 4; d++) begin
        m_hist[d].delete();
        m_deb[d] = 1'b0;
        m_req[d] = 1'b0;
        m_run[d] = 0;
      end
      exp_q.delete();
    end else begin
      logic [3:0] e_req;
      logic [3:0] e_stk;
      for (int d = 0; d < 4; d++) begin
        bit old_deb;
        bit all_diff;
        old_deb = m_deb[d];
        m_hist[d].push_back(det[d]);
        if (g[d])         m_req[d] = 1'b0;
        else if (old_deb) m_req[d] = 1'b1;
        if (old_deb) m_run[d] = (m_run[d] < STK) ? m_run[d] + 1 : STK;
        else         m_run[d] = 0;
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          int idx;
          bit v;
          idx = m_hist[d].size() - 3 - k;
          v = (idx >= 0) ? m_hist[d][idx] : 1'b0;
          if (v == old_deb) all_diff = 1'b0;
        end
        if (all_diff) m_deb[d] = !old_deb;
        while (m_hist[d].size() > DEB + 3) void'(m_hist[d].pop_front());
        e_req[d] = m_req[d];
        e_stk[d] = (m_run[d] == STK);
      end
      exp_q.push_back({e_stk, e_req});
    end
  end

  // scoreboard: every cycle out of reset, compare against the model mid-cycle
  always @(negedge clk) begin
    if (reset_n && exp_q.size() > 0) begin
      logic [7:0] exp_v;
      exp_v = exp_q.pop_front();
      checks++;
      if ({stuck, req} !== exp_v) begin
        errors++;
        $display("FAIL model_cmp t=%0t got stuck=%b req=%b expected stuck=%b req=%b",
                 $time, stuck, req, exp_v[7:4], exp_v[3:0]);
      end
    end
  end

  // driver / checker tasks
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp_v);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    det = '0;
    g = '0;
    #1;
    check("reset_req", req, 4'b0000);
    check("reset_stuck", stuck, 4'b0000);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: async reset clears a latched north request before the next edge
    do_reset();
    @(negedge clk) det[0] = 1'b1;
    repeat (10) step();
    check("pre_reset_n", req, 4'b0001);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_n", req, 4'b0000);
    check("async_reset_stuck", stuck, 4'b0000);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // 2: clean east press, latch after release, single-cycle green clears
    do_reset();
    @(negedge clk) det[1] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      check($sformatf("press_e_edge%0d", e), {3'b000, req[1]}, {3'b000, e == 7});
    end
    @(negedge clk) det[1] = 1'b0;
    repeat (10) step();
    check("e_held_after_leave", req, 4'b0010);
    @(negedge clk) g[1] = 1'b1;
    step();
    check("e_cleared_by_green", req, 4'b0000);
    @(negedge clk) g[1] = 1'b0;
    repeat (5) step();
    check("e_stays_clear", req, 4'b0000);

    // 3: south bounce (3 high, 2 low, 2 high) rejected, then a solid press accepted
    do_reset();
    @(negedge clk) det[2] = 1'b1;
    repeat (3) @(negedge clk);
    det[2] = 1'b0;
    repeat (2) @(negedge clk);
    det[2] = 1'b1;
    repeat (2) @(negedge clk);
    det[2] = 1'b0;
    repeat (12) step();
    check("s_bounce_rejected", req, 4'b0000);
    @(negedge clk) det[2] = 1'b1;
    repeat (10) step();
    check("s_solid_press", req, 4'b0100);
    @(negedge clk) det[2] = 1'b0;

    // 4: west green clears over a held detector, re-request right after green
    do_reset();
    @(negedge clk) det[3] = 1'b1;
    repeat (7) step();
    check("w_request", req, 4'b1000);
    @(negedge clk) g[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("w_green_cyc%0d", i), req, 4'b0000);
    end
    @(negedge clk) g[3] = 1'b0;
    step();
    check("w_rerequest", req, 4'b1000);

    // 5: north stuck high with green toggling, then release
    do_reset();
    for (int e = 1; e <= 85; e++) begin
      @(negedge clk);
      det[0] = 1'b1;
      g[0] = ((e / 8) % 2) == 1;
      step();
      if (e == 69) check("stuck_n_edge69", stuck, 4'b0000);
      if (e == 70) check("stuck_n_edge70", stuck, 4'b0001);
      if (e == 80) check("n_served_green", {3'b000, req[0]}, {3'b000, !g[0]});
    end
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      det[0] = 1'b0;
      g[0] = 1'b0;
      step();
      if (e == 6) check("stuck_n_hold", stuck, 4'b0001);
      if (e == 7) check("stuck_n_clear", stuck, 4'b0000);
    end
    @(negedge clk) det[0] = 1'b1;
    repeat (75) step();
    check("stuck_again", stuck, 4'b0001);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_stuck_n", stuck, 4'b0000);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // 6: all four rise together, greens served one at a time
    do_reset();
    @(negedge clk) det = 4'hF;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 6) check("all_edge6", req, 4'b0000);
      if (e == 7) check("all_edge7", req, 4'b1111);
    end
    @(negedge clk) det = 4'h0;
    repeat (10) step();
    check("all_held", req, 4'b1111);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] exp_v;
      exp_v = 4'hF << (d + 1);
      @(negedge clk) g = 4'b0001 << d;
      step();
      check($sformatf("serve_dir%0d", d), req, exp_v);
      @(negedge clk) g = 4'b0000;
    end
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
